// File: rtl/ppla_spi_shifter.sv
// ---------------------------------------------------------------------------
// ppla_spi_shifter
//
// SPI mode-0 master transaction engine. Each accepted KICK runs one
// single-word, MSB-first transfer of N bits (N = TX_BITS, with 0 or >32
// meaning 32). Received bits are shifted in on every rising SCLK edge and
// presented right-aligned, zero-extended on RX_DATA with a one-cycle
// RX_VALID strobe on the edge where chip select is released.
//
// Optional feature: define PPLA_SPI_LOOPBACK_EN to add the LOOPBACK input.
// With LOOPBACK=1 the bit captured on each rising SCLK edge is the current
// SPI_MOSI instead of SPI_MISO; the SPI pins still toggle normally.
//
// Parameters
//   HALF_PERIOD  CLK cycles per SCLK half-period (H), legal 1..255
//
// Ports
//   CLK        system clock
//   RESET      synchronous, active-high reset
//   KICK       start request, level-sampled while idle
//   BUSY       high from kick acceptance until the end of the transfer
//   TX_DATA    transmit word, right-aligned (low N bits are sent)
//   TX_BITS    transfer length N (0 or >32 means 32)
//   RX_DATA    received word, right-aligned, zero-extended
//   RX_VALID   one-cycle strobe, RX_DATA updated
//   SPI_SCLK   serial clock, idles low
//   SPI_CS_N   chip select, active low
//   SPI_MOSI   serial data out
//   SPI_MISO   serial data in
//   LOOPBACK   (PPLA_SPI_LOOPBACK_EN only) capture MOSI instead of MISO
// ---------------------------------------------------------------------------
module ppla_spi_shifter #(
  parameter int HALF_PERIOD = 4
) (
  input  logic        CLK,
  input  logic        RESET,
`ifdef PPLA_SPI_LOOPBACK_EN
  input  logic        LOOPBACK,
`endif
  input  logic        KICK,
  output logic        BUSY,
  input  logic [31:0] TX_DATA,
  input  logic [5:0]  TX_BITS,
  output logic [31:0] RX_DATA,
  output logic        RX_VALID,
  output logic        SPI_SCLK,
  output logic        SPI_CS_N,
  output logic        SPI_MOSI,
  input  logic        SPI_MISO
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SCLK_HI,
    S_SCLK_LO,
    S_HOLD,
    S_GAP
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(HALF_PERIOD - 1);

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [31:0] tx_q, tx_d;
  logic [31:0] rx_shift_q, rx_shift_d;
  logic [31:0] rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        busy_q, busy_d;
  logic        sclk_q, sclk_d;
  logic        cs_n_q, cs_n_d;
  logic        mosi_q, mosi_d;

  logic        div_done;
  logic [5:0]  n_req;
  logic [5:0]  first_idx;
  logic [5:0]  next_idx;
  logic        sample_bit;

  // Every non-idle state lasts exactly one half-period; the divider wraps on
  // the same edge the state changes.
  assign div_done  = (div_q == DIV_LAST);
  assign n_req     = ((TX_BITS == 6'd0) || (TX_BITS > 6'd32)) ? 6'd32 : TX_BITS;
  assign first_idx = n_req - 6'd1;
  assign next_idx  = bit_cnt_q - 6'd2;

`ifdef PPLA_SPI_LOOPBACK_EN
  assign sample_bit = LOOPBACK ? mosi_q : SPI_MISO;
`else
  assign sample_bit = SPI_MISO;
`endif

  always_comb begin
    // NOTE: every *_d gets its hold value first so no path through the case
    // leaves a signal unassigned (which would infer a latch).
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tx_d       = tx_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    busy_d     = busy_q;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    mosi_d     = mosi_q;
    div_d      = ((state_q == S_IDLE) || div_done) ? 8'd0 : div_q + 8'd1;

    unique case (state_q)
      S_IDLE: begin
        // Acceptance raises BUSY on the sampling edge itself so the upstream
        // repeater sees it one cycle after its kick pulse.
        if (KICK) begin
          busy_d     = 1'b1;
          cs_n_d     = 1'b0;
          tx_d       = TX_DATA;
          bit_cnt_d  = n_req;
          mosi_d     = TX_DATA[first_idx[4:0]];
          rx_shift_d = '0;
          state_d    = S_SETUP;
        end
      end

      S_SETUP: begin
        if (div_done) begin
          sclk_d     = 1'b1;
          rx_shift_d = {rx_shift_q[30:0], sample_bit};
          state_d    = S_SCLK_HI;
        end
      end

      S_SCLK_HI: begin
        if (div_done) begin
          sclk_d    = 1'b0;
          bit_cnt_d = bit_cnt_q - 6'd1;
          // MOSI moves only on the falling edge, and only while bits remain;
          // after the last bit it holds its value.
          if (bit_cnt_q != 6'd1) begin
            mosi_d = tx_q[next_idx[4:0]];
          end
          state_d = S_SCLK_LO;
        end
      end

      S_SCLK_LO: begin
        if (div_done) begin
          // With the counter exhausted, the last bit still gets its full
          // SCLK-low half-period before the CS hold window starts.
          if (bit_cnt_q == 6'd0) begin
            state_d = S_HOLD;
          end else begin
            sclk_d     = 1'b1;
            rx_shift_d = {rx_shift_q[30:0], sample_bit};
            state_d    = S_SCLK_HI;
          end
        end
      end

      S_HOLD: begin
        if (div_done) begin
          cs_n_d     = 1'b1;
          mosi_d     = 1'b0;
          rx_data_d  = rx_shift_q;
          rx_valid_d = 1'b1;
          state_d    = S_GAP;
        end
      end

      S_GAP: begin
        if (div_done) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      // NOTE: the shift and latched-word registers are reset as well; an
      // aborted transfer must leave RX_DATA and all counters at zero.
      state_q    <= S_IDLE;
      div_q      <= '0;
      bit_cnt_q  <= '0;
      tx_q       <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_q       <= tx_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      mosi_q     <= mosi_d;
    end
  end

  assign BUSY     = busy_q;
  assign RX_DATA  = rx_data_q;
  assign RX_VALID = rx_valid_q;
  assign SPI_SCLK = sclk_q;
  assign SPI_CS_N = cs_n_q;
  assign SPI_MOSI = mosi_q;

endmodule
